// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - command opcodes, fixed operand addresses and FSM state encoding for sys_ctrl
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN_S,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - command sequencer: decodes RX byte frames into register-file
// accesses and ALU operations, and returns results to the TX FIFO.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int FRAME_WIDTH         = 8,
  parameter int ALU_DATA_WIDTH      = 16,
  parameter int ALU_FUNC_WIDTH      = 4,
  parameter int REG_FILE_ADDR_WIDTH = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [FRAME_WIDTH-1:0]         RX_P_DATA,
  input  logic                           RX_D_VLD,
  input  logic [FRAME_WIDTH-1:0]         RdData,
  input  logic                           RdData_Valid,
  input  logic [ALU_DATA_WIDTH-1:0]      ALU_OUT,
  input  logic                           OUT_Valid,
  input  logic                           FIFO_FULL,
  output logic                           WrEn,
  output logic                           RdEn,
  output logic [REG_FILE_ADDR_WIDTH-1:0] Address,
  output logic [FRAME_WIDTH-1:0]         WrData,
  output logic                           ALU_EN,
  output logic [ALU_FUNC_WIDTH-1:0]      ALU_FUN,
  output logic                           CLK_EN,
  output logic [FRAME_WIDTH-1:0]         TX_P_DATA,
  output logic                           TX_D_VLD
);

  localparam int FW = FRAME_WIDTH;
  localparam int RA = REG_FILE_ADDR_WIDTH;
  localparam int FF = ALU_FUNC_WIDTH;

  state_t               r_state, w_state_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic                 r_rd_en, w_rd_en_nxt;
  logic [RA-1:0]        r_address, w_address_nxt;
  logic [FW-1:0]        r_wr_data, w_wr_data_nxt;
  logic                 r_alu_en, w_alu_en_nxt;
  logic [FF-1:0]        r_alu_fun, w_alu_fun_nxt;
  logic                 r_clk_en, w_clk_en_nxt;
  logic                 r_alu_pend, w_alu_pend_nxt;
  logic [RA-1:0]        r_addr_hold, w_addr_hold_nxt;
  logic [FW-1:0]        r_tx_lo, w_tx_lo_nxt;
  logic [FW-1:0]        r_tx_hi, w_tx_hi_nxt;
  logic                 r_tx_single, w_tx_single_nxt;
  logic                 w_tx_vld;
  logic [RA-1:0]        w_rx_addr;
  logic [FF-1:0]        w_rx_fun;

  assign w_rx_addr = RX_P_DATA[RA-1:0];
  assign w_rx_fun  = RX_P_DATA[FF-1:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_alu_en_nxt    = 1'b0;
    w_address_nxt   = r_address;
    w_wr_data_nxt   = r_wr_data;
    w_alu_fun_nxt   = r_alu_fun;
    w_clk_en_nxt    = r_clk_en;
    w_alu_pend_nxt  = r_alu_pend;
    w_addr_hold_nxt = r_addr_hold;
    w_tx_lo_nxt     = r_tx_lo;
    w_tx_hi_nxt     = r_tx_hi;
    w_tx_single_nxt = r_tx_single;
    w_tx_vld        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_RF_WR:   w_state_nxt = ST_WR_ADDR;
            CMD_RF_RD:   w_state_nxt = ST_RD_ADDR;
            CMD_ALU_OP:  w_state_nxt = ST_OP_A;
            CMD_ALU_NOP: w_state_nxt = ST_ALU_FUN_S;
            default:     w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          w_addr_hold_nxt = w_rx_addr;
          w_state_nxt     = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          w_wr_en_nxt   = 1'b1;
          w_address_nxt = r_addr_hold;
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          w_rd_en_nxt   = 1'b1;
          w_address_nxt = w_rx_addr;
          w_state_nxt   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RdData_Valid) begin
          w_tx_lo_nxt     = RdData;
          w_tx_single_nxt = 1'b1;
          w_state_nxt     = ST_TX_LO;
        end
      end
      ST_OP_A: begin
        if (RX_D_VLD) begin
          w_wr_en_nxt   = 1'b1;
          w_address_nxt = RA'(OPA_ADDR);
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_OP_B;
        end
      end
      ST_OP_B: begin
        if (RX_D_VLD) begin
          w_wr_en_nxt   = 1'b1;
          w_address_nxt = RA'(OPB_ADDR);
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_ALU_FUN_S;
        end
      end
      ST_ALU_FUN_S: begin
        if (RX_D_VLD) begin
          w_alu_fun_nxt  = w_rx_fun;
          w_clk_en_nxt   = 1'b1;
          w_alu_pend_nxt = 1'b1;
          w_state_nxt    = ST_ALU_WAIT;
        end
      end
      // ALU_EN fires one cycle after CLK_EN so the gated ALU clock is running first.
      ST_ALU_WAIT: begin
        if (r_alu_pend) begin
          w_alu_en_nxt   = 1'b1;
          w_alu_pend_nxt = 1'b0;
        end else if (OUT_Valid) begin
          w_tx_lo_nxt     = ALU_OUT[FW-1:0];
          w_tx_hi_nxt     = ALU_OUT[2*FW-1:FW];
          w_tx_single_nxt = 1'b0;
          w_state_nxt     = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        w_tx_vld = !FIFO_FULL;
        if (!FIFO_FULL) begin
          w_state_nxt = r_tx_single ? ST_IDLE : ST_TX_HI;
        end
      end
      ST_TX_HI: begin
        w_tx_vld = !FIFO_FULL;
        if (!FIFO_FULL) begin
          w_clk_en_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_alu_en    <= 1'b0;
      r_address   <= '0;
      r_wr_data   <= '0;
      r_alu_fun   <= '0;
      r_clk_en    <= 1'b0;
      r_alu_pend  <= 1'b0;
      r_addr_hold <= '0;
      r_tx_lo     <= '0;
      r_tx_hi     <= '0;
      r_tx_single <= 1'b0;
    end else begin
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_alu_en    <= w_alu_en_nxt;
      r_address   <= w_address_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_alu_fun   <= w_alu_fun_nxt;
      r_clk_en    <= w_clk_en_nxt;
      r_alu_pend  <= w_alu_pend_nxt;
      r_addr_hold <= w_addr_hold_nxt;
      r_tx_lo     <= w_tx_lo_nxt;
      r_tx_hi     <= w_tx_hi_nxt;
      r_tx_single <= w_tx_single_nxt;
    end
  end

  // TX strobe is combinational on FIFO_FULL so a byte is never written into a full FIFO.
  assign TX_D_VLD  = w_tx_vld;
  assign TX_P_DATA = (r_state == ST_TX_HI) ? r_tx_hi :
                     (r_state == ST_TX_LO) ? r_tx_lo : '0;

  assign WrEn    = r_wr_en;
  assign RdEn    = r_rd_en;
  assign Address = r_address;
  assign WrData  = r_wr_data;
  assign ALU_EN  = r_alu_en;
  assign ALU_FUN = r_alu_fun;
  assign CLK_EN  = r_clk_en;

endmodule

// File: tb/tb_sys_ctrl.sv
// tb/tb_sys_ctrl.sv - scoreboard bench for sys_ctrl with register-file and ALU responders
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, TX_P_DATA;

  sys_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
    .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_cyc = 0;
  int tx_cyc   = 0;
  int tx_count = 0;
  int alu_cnt  = 0;
  logic [15:0] alu_val = '0;
  logic [7:0]  mem [16];

  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [7:0]  tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Register-file responder: read data returned one cycle after RdEn.
  always @(negedge CLK) begin
    if (WrEn) mem[Address] = WrData;
    if (RdEn) begin
      RdData = mem[Address];
      RdData_Valid = 1'b1;
    end else begin
      RdData_Valid = 1'b0;
    end
  end

  // ALU responder: OUT_Valid two cycles after ALU_EN.
  always @(negedge CLK) begin
    if (ALU_EN) begin
      alu_cnt = 2;
      OUT_Valid = 1'b0;
    end else if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        OUT_Valid = 1'b1;
        ALU_OUT = alu_val;
      end
    end else begin
      OUT_Valid = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn && RdEn) check("wr_rd_exclusive", 1, 0);
      if (TX_D_VLD && FIFO_FULL) check("tx_while_full", 1, 0);
      if (WrEn) begin
        if (wr_q.size() == 0) check("unexpected_wren", {20'd0, Address, WrData}, 0);
        else check("wren_addr_data", {20'd0, Address, WrData}, {20'd0, wr_q.pop_front()});
      end
      if (RdEn) begin
        if (rd_q.size() == 0) check("unexpected_rden", {28'd0, Address}, 0);
        else check("rden_addr", {28'd0, Address}, {28'd0, rd_q.pop_front()});
      end
      if (ALU_EN) begin
        check("alu_en_clk_en", {31'd0, CLK_EN}, 1);
        if (alu_q.size() == 0) check("unexpected_alu_en", {28'd0, ALU_FUN}, 0);
        else check("alu_fun", {28'd0, ALU_FUN}, {28'd0, alu_q.pop_front()});
      end
      if (TX_D_VLD) begin
        tx_count++;
        tx_cyc = cyc;
        if (tx_q.size() == 0) check("unexpected_tx", {24'd0, TX_P_DATA}, 0);
        else check("tx_byte", {24'd0, TX_P_DATA}, {24'd0, tx_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(posedge CLK);
    #1;
    last_cyc = cyc;
    RX_D_VLD = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()) != 0 && k < 500) begin
      @(posedge CLK);
      k++;
    end
    check(name, wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size(), 0);
    repeat (3) @(posedge CLK);
  endtask

  int tx_before;
  int k;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[7] = 8'h99;

    #23;
    check("rst_strobes", {27'd0, WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD}, 0);
    check("rst_addr_data", {12'd0, Address, WrData, ALU_FUN}, 0);
    check("rst_tx_data", {24'd0, TX_P_DATA}, 0);
    @(posedge CLK);
    #1 RST = 1'b1;

    // RF write
    wr_q.push_back({4'h5, 8'h3C});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    wait_idle("rf_wr_done");
    check("rf_wr_no_tx", tx_count, 0);

    // RF read with latency bound
    rd_q.push_back(4'h5);
    tx_q.push_back(8'h3C);
    send_byte(8'hBB); send_byte(8'h05);
    wait_idle("rf_rd_done");
    check("rf_rd_latency_le3", ((tx_cyc - last_cyc) <= 3) ? 1 : 0, 1);

    // ALU op with operands
    alu_val = 16'h000D;
    wr_q.push_back({4'h0, 8'h0A});
    wr_q.push_back({4'h1, 8'h03});
    alu_q.push_back(4'h0);
    tx_q.push_back(8'h0D);
    tx_q.push_back(8'h00);
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
    wait_idle("alu_op_done");
    check("alu_op_clk_en_low", {31'd0, CLK_EN}, 0);

    // ALU nop with TX FIFO full for 20 cycles
    FIFO_FULL = 1'b1;
    alu_val = 16'hBEEF;
    alu_q.push_back(4'h2);
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'hBE);
    tx_before = tx_count;
    send_byte(8'hDD); send_byte(8'h02);
    repeat (20) @(posedge CLK);
    #1;
    check("full_no_tx", tx_count - tx_before, 0);
    check("full_clk_en_held", {31'd0, CLK_EN}, 1);
    FIFO_FULL = 1'b0;
    wait_idle("alu_nop_done");
    check("full_two_bytes", tx_count - tx_before, 2);
    check("alu_nop_clk_en_low", {31'd0, CLK_EN}, 0);

    // Unknown byte ignored, then read of addr 1 (written as operand B)
    rd_q.push_back(4'h1);
    tx_q.push_back(8'h03);
    send_byte(8'h55); send_byte(8'hBB); send_byte(8'h01);
    wait_idle("ignore_then_read");

    // Reset in the middle of an RF write
    send_byte(8'hAA); send_byte(8'h07);
    #3 RST = 1'b0;
    #1;
    check("midrst_strobes", {27'd0, WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD}, 0);
    check("midrst_addr", {28'd0, Address}, 0);
    @(negedge CLK);
    RST = 1'b1;
    rd_q.push_back(4'h7);
    tx_q.push_back(8'h99);
    send_byte(8'hBB); send_byte(8'h07);
    wait_idle("midrst_read");

    // Reset while CLK_EN held by a stalled ALU result
    FIFO_FULL = 1'b1;
    alu_val = 16'h1234;
    alu_q.push_back(4'h4);
    send_byte(8'hDD); send_byte(8'h04);
    k = 0;
    while (alu_q.size() != 0 && k < 100) begin
      @(posedge CLK);
      k++;
    end
    check("async_alu_started", alu_q.size(), 0);
    repeat (4) @(posedge CLK);
    #1;
    check("async_clk_en_before", {31'd0, CLK_EN}, 1);
    #2 RST = 1'b0;
    #1;
    check("async_clk_en_drop", {31'd0, CLK_EN}, 0);
    @(negedge CLK);
    FIFO_FULL = 1'b0;
    RST = 1'b1;
    tx_before = tx_count;
    wr_q.push_back({4'hF, 8'h5A});
    send_byte(8'hAA); send_byte(8'h0F); send_byte(8'h5A);
    wait_idle("post_rst_write");
    check("post_rst_no_tx", tx_count - tx_before, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
